// File: rtl/dcache_ctrl.sv
//------------------------------------------------------------------------------
// dcache_ctrl : direct-mapped 8x4-word write-back, write-allocate data cache
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_valid;
  logic [7:0]    r_dirty;
  logic [24:0]   r_tag  [8];
  logic [127:0]  r_data [8];

  logic [2:0]    w_idx;
  logic [1:0]    w_off;
  logic [24:0]   w_tag;
  logic          w_req;
  logic          w_hit;
  logic          w_miss;
  logic          w_wr_hit;
  logic [127:0]  w_line;
  logic [31:0]   w_word;
  logic [127:0]  w_merged;

  assign w_idx    = proc_addr[4:2];
  assign w_off    = proc_addr[1:0];
  assign w_tag    = proc_addr[29:5];
  assign w_req    = proc_read | proc_write;
  assign w_hit    = w_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss   = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_wr_hit = (r_state == S_IDLE) && w_hit && proc_write;
  assign w_line   = r_data[w_idx];

  always_comb begin
    w_word   = w_line[31:0];
    w_merged = w_line;
    case (w_off)
      2'd0: begin w_word = w_line[31:0];   w_merged[31:0]   = proc_wdata; end
      2'd1: begin w_word = w_line[63:32];  w_merged[63:32]  = proc_wdata; end
      2'd2: begin w_word = w_line[95:64];  w_merged[95:64]  = proc_wdata; end
      default: begin w_word = w_line[127:96]; w_merged[127:96] = proc_wdata; end
    endcase
  end

  // Stall is gated by rst because a held request during reset would otherwise look like a miss.
  assign proc_stall = rst && (w_miss || (r_state != S_IDLE));
  assign proc_rdata = ((r_state == S_IDLE) && w_hit && proc_read && !proc_write) ? w_word : 32'd0;
  assign mem_write  = (r_state == S_WRITEBACK);
  assign mem_read   = (r_state == S_ALLOCATE);
  assign mem_wdata  = (r_state == S_WRITEBACK) ? w_line : 128'd0;

  always_comb begin
    mem_addr = 28'd0;
    case (r_state)
      S_WRITEBACK: mem_addr = {r_tag[w_idx], w_idx};
      S_ALLOCATE:  mem_addr = {w_tag, w_idx};
      default:     mem_addr = 28'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_valid <= 8'd0;
      r_dirty <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      r_data[w_idx] <= w_merged;
    end else if ((r_state == S_ALLOCATE) && mem_ready) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end
  end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port proc_read, input, 1 bit: load request from MEM stage.
REQ-004 SHALL have port proc_write, input, 1 bit: store request from MEM stage.
REQ-005 SHALL have port proc_addr, input, 30 bits: word address; [1:0] word offset, [4:2] index, [29:5] tag.
REQ-006 SHALL have port proc_wdata, input, 32 bits: store data.
REQ-007 SHALL have port proc_rdata, output, 32 bits: load data, consumed by the MEM/WB register as its read data.
REQ-008 SHALL have port proc_stall, output, 1 bit: pipeline freeze while a miss is serviced.
REQ-009 SHALL have port mem_read, output, 1 bit: line fill request.
REQ-010 SHALL have port mem_write, output, 1 bit: line writeback request.
REQ-011 SHALL have port mem_addr, output, 28 bits: line address {tag,index}.
REQ-012 SHALL have port mem_wdata, output, 128 bits: victim line, word 0 in bits [31:0].
REQ-013 SHALL have port mem_rdata, input, 128 bits: fill line, word 0 in bits [31:0].
REQ-014 SHALL have port mem_ready, input, 1 bit: memory completion, asserted for one cycle per request.

Function
REQ-015 SHALL be direct-mapped, 8 lines x 4 words, with a valid bit, a dirty bit and a 25-bit tag per line, write-back and write-allocate.
REQ-016 SHALL detect a hit combinationally: the request is active, the line at proc_addr[4:2] is valid, and its tag equals proc_addr[29:5].
REQ-017 SHALL drive proc_rdata combinationally with the addressed word on a read hit in IDLE, and 0 otherwise.
REQ-018 SHALL write proc_wdata into the addressed word and set dirty on the clk edge of a write hit; proc_stall stays 0, so hits cost zero stall cycles.
REQ-019 SHALL use FSM states IDLE, WRITEBACK and ALLOCATE.
REQ-020 SHALL, on a miss in IDLE, go to WRITEBACK if the victim is valid and dirty, and to ALLOCATE otherwise.
REQ-021 SHALL assert proc_stall combinationally in the miss cycle and in every cycle spent in WRITEBACK or ALLOCATE.
REQ-022 SHALL, in WRITEBACK, hold mem_write=1 with mem_addr={victim tag,index} and mem_wdata=victim line; on mem_ready it clears dirty and goes to ALLOCATE.
REQ-023 SHALL, in ALLOCATE, hold mem_read=1 with mem_addr={proc_addr[29:5],index}; on mem_ready it loads mem_rdata, sets valid, sets the new tag, clears dirty and returns to IDLE.
REQ-024 SHALL, on return to IDLE, re-evaluate the still-held request as a hit; stores therefore merge into the filled line one cycle after the fill.
REQ-025 SHALL keep mem_read and mem_write mutually exclusive, and both 0 in IDLE.
REQ-026 SHALL give proc_write priority when proc_write and proc_read are both 1, treating the access as a store.
REQ-027 SHALL produce no state change and no stall when there is no request.
REQ-028 SHALL ignore mem_ready in IDLE.
REQ-029 SHALL bound miss latency as the WRITEBACK wait plus the ALLOCATE wait plus 1 cycle.

Reset
REQ-030 SHALL, while rst=0, force the FSM to IDLE, clear all valid and dirty bits, and drive proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 and proc_rdata=0.
REQ-031 SHALL, on reset asserted mid-miss, abandon the outstanding request immediately; data and tag arrays need not be cleared.

Verification
REQ-032 SHALL cover this scenario: after reset, read addr 0x10 -> stall=1, mem_read=1 with mem_addr=0x4; mem_ready with rdata word0=0xAAAA5555 -> next cycle stall=0 and proc_rdata=0xAAAA5555.
REQ-033 SHALL cover this scenario: write 0x12345678 to addr 0x11 on a resident line -> no stall; a read of 0x11 then returns 0x12345678.
REQ-034 SHALL cover this scenario: line dirty at index 4, read addr 0x30 (same index, new tag) -> mem_write with mem_addr=0x4 and the dirty line, then mem_read with mem_addr=0xC, then a hit.
REQ-035 SHALL cover this scenario: write miss to a clean line -> ALLOCATE only, with no mem_write; the word merges after the fill and dirty=1.
REQ-036 SHALL cover this scenario: rst pulsed during ALLOCATE -> mem_read=0 and stall=0 immediately, and a re-read of the same address misses.
REQ-037 SHALL cover this scenario: mem_ready delayed 10 cycles -> stall held for the whole wait and the request signals stay stable.
